// File: rtl/ascii_decimal_parser.sv
// rtl/ascii_decimal_parser.sv - ASCII decimal digit stream to saturating binary value
// Multiply-by-10-and-add accumulator; result is held in DONE until the consumer takes it.
module ascii_decimal_parser #(
   parameter int H          = 32,
   parameter int V          = 32,
   parameter int MAX_DIGITS = 4,
   localparam int W         = $clog2(H * V)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [6:0]   char_in,
   input  logic         char_valid,
   output logic         char_ready,
   output logic [W-1:0] value,
   output logic         value_valid,
   input  logic         value_ready,
   output logic         overflow,
   output logic         error,
   output logic [2:0]   digit_count
);

   localparam logic       ST_ACCUM = 1'b0;
   localparam logic       ST_DONE  = 1'b1;
   localparam int         MAXV     = H * V - 1;
   localparam logic [2:0] DMAX     = 3'(MAX_DIGITS);

   logic         state_q, state_d;
   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] value_q, value_d;
   logic         value_valid_q, value_valid_d;
   logic         overflow_q, overflow_d;
   logic         error_q, error_d;
   logic [2:0]   digit_count_q, digit_count_d;
   logic         char_ready_q, char_ready_d;

   logic         accept;
   logic         is_digit;
   logic         is_term;
   logic         is_esc;
   logic [W+3:0] acc_ext;
   logic [W+3:0] t;

   assign accept   = char_valid & char_ready_q;
   assign is_digit = (char_in >= 7'd48) && (char_in <= 7'd57);
   assign is_term  = (char_in == 7'd13) || (char_in == 7'd32);
   assign is_esc   = (char_in == 7'd27);
   assign acc_ext  = {4'b0000, acc_q};
   assign t        = (acc_ext << 3) + (acc_ext << 1) + {{W{1'b0}}, char_in[3:0]};

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      value_d       = value_q;
      value_valid_d = value_valid_q;
      overflow_d    = overflow_q;
      error_d       = error_q;
      digit_count_d = digit_count_q;

      if (state_q == ST_ACCUM) begin
         if (accept) begin
            if (is_digit) begin
               if (!error_q) begin
                  if (digit_count_q == DMAX) begin
                     overflow_d = 1'b1;
                  end else begin
                     if (t > (W+4)'(MAXV)) begin
                        acc_d      = W'(MAXV);
                        overflow_d = 1'b1;
                     end else begin
                        acc_d = t[W-1:0];
                     end
                     digit_count_d = digit_count_q + 3'd1;
                  end
               end
            end else if (is_term) begin
               if (digit_count_q != 3'd0 || error_q) begin
                  value_d       = error_q ? '0 : acc_q;
                  value_valid_d = 1'b1;
                  state_d       = ST_DONE;
               end
            end else if (is_esc) begin
               acc_d         = '0;
               digit_count_d = 3'd0;
               overflow_d    = 1'b0;
               error_d       = 1'b0;
            end else begin
               error_d = 1'b1;
            end
         end
      end else begin
         if (value_valid_q && value_ready) begin
            value_valid_d = 1'b0;
            acc_d         = '0;
            digit_count_d = 3'd0;
            overflow_d    = 1'b0;
            error_d       = 1'b0;
            state_d       = ST_ACCUM;
         end
      end
   end

   // Ready only once the state has settled in ACCUM, giving the idle cycle after a handshake.
   assign char_ready_d = (state_q == ST_ACCUM) && (state_d == ST_ACCUM);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_ACCUM;
         acc_q         <= '0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
         error_q       <= 1'b0;
         digit_count_q <= 3'd0;
         char_ready_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         overflow_q    <= overflow_d;
         error_q       <= error_d;
         digit_count_q <= digit_count_d;
         char_ready_q  <= char_ready_d;
      end
   end

   assign char_ready  = char_ready_q;
   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign overflow    = overflow_q;
   assign error       = error_q;
   assign digit_count = digit_count_q;

endmodule

// File: doc/ascii_decimal_parser.md
Name: ascii_decimal_parser

Overview:
- Decodes a stream of 7-bit ASCII characters holding decimal digits, e.g. typed score or level entry, into one binary value.
- It is the inverse of the on-screen score printer, which emits characters as 48 + digit.
- It sits between a character source (keyboard/UART front end) and game logic that consumes a binary score/limit in the same range as the printed score (0 .. H*V-1).
- Sequential multiply-by-10-and-add accumulator with valid/ready handshakes on both sides.

Parameters:
- H, 32, playfield columns; value range upper bound is H*V-1.
- V, 32, playfield rows.
- MAX_DIGITS, 4, maximum decimal digits accepted per number; more sets overflow.
- W (localparam), logb2(H*V) = 10, value width, using ceil-log2 as the printer does.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- char_in  in  7  ASCII character
- char_valid  in  1  char_in valid this cycle
- char_ready  out  1  parser can accept a character
- value  out  W  decoded binary value
- value_valid  out  1  value/overflow/error valid
- value_ready  in  1  consumer accepts value
- overflow  out  1  result saturated (qualified by value_valid)
- error  out  1  illegal character seen (qualified by value_valid)
- digit_count  out  3  digits accepted in current number (for echo/cursor display)

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=ACCUM, acc=0, digit_count=0, overflow=0, error=0, value=0, value_valid=0, char_ready=0 during the reset cycle, then 1.
- States: ACCUM, DONE.
- ACCUM: char_ready=1. A character is accepted when char_valid & char_ready.
- '0'..'9' (48..57), d = char_in-48:
  - if error already set: discarded.
  - else if digit_count == MAX_DIGITS: overflow<=1, acc unchanged.
  - else: compute t = acc*10 + d in W+4 bits, with acc*10 as (acc<<3)+(acc<<1).
    - if t > H*V-1: acc<=H*V-1, overflow<=1.
    - else acc<=t.
    - digit_count increments, saturating at MAX_DIGITS.
- Terminator CR (13) or space (32):
  - if digit_count==0 and error==0: ignored, stay in ACCUM, no output.
  - else: value<=(error ? 0 : acc), value_valid<=1, state<=DONE.
- ESC (27): acc, digit_count, overflow, error cleared; no output.
- Any other code: error<=1; further digits are discarded until a terminator.
- Terminator with digit_count==0 and error==1 still produces output.
- DONE:
  - char_ready=0; value, overflow, error and digit_count held stable.
  - When value_valid & value_ready: value_valid<=0, acc<=0, digit_count<=0, overflow<=0, error<=0, state<=ACCUM.
  - char_ready rises on the next cycle.
- Latency: terminator accepted on edge n; value_valid is high after edge n (visible in cycle n+1). Minimum 1 idle cycle between a handshake and the next accepted character.
- All outputs are registered; no combinational path from char_valid or value_ready to any output. char_ready depends on state only.
- Reset mid-number or during DONE discards everything; there is no partial output.
- No leading-zero special case: "007" gives 7 and counts 3 digits.
- Max-value boundary: for H=V=32, 1023 is legal; 1024 saturates to 1023 with overflow=1.

Test Plan:
- '1','2','3',CR back to back -> one cycle after CR: value_valid=1, value=123, overflow=0, error=0, digit_count=3; value_ready=1 -> value_valid=0 next cycle, char_ready=1 the cycle after.
- "1023",' ' then "1024",CR -> first value=1023 overflow=0; second value=1023 overflow=1.
- "12345",CR (MAX_DIGITS=4) -> value=1023 overflow=1, because 1234>1023; with H=V=128 (W=14) -> value=1234 overflow=1, digit_count=4.
- "1A2",CR -> value_valid=1, value=0, error=1; then "9",CR -> value=9 error=0.
- "56" then value_ready=0 after CR for 5 cycles -> value=56 stable, char_ready=0, chars presented are not consumed; ESC mid-entry "8",ESC,"3",CR -> value=3.
- "45", rst pulse, "7",CR -> value=7; lone CR or ' ' with no digits -> value_valid stays 0.
